// File: rtl/cgra_clock_gate_ctrl.sv
// Per-tile clock-gate controller: gates a tile after a programmable idle period, ungates it on wake; outputs registered (1 edge).
// No backpressure; optional CGRA_CG_WAKE_STAGGER_EN limits wake grants to one round-robin tile per cycle.
module cgra_clock_gate_ctrl #(
  parameter int N_TILES  = 16,
  parameter int IDLE_W   = 8,
  parameter int WAKE_LAT = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_enable_i,
  input  logic [IDLE_W-1:0]  cfg_idle_thr_i,
  input  logic               test_en_i,
  input  logic [N_TILES-1:0] busy_i,
  input  logic [N_TILES-1:0] wake_req_i,
  output logic [N_TILES-1:0] clk_en_o,
  output logic [N_TILES-1:0] tile_ready_o,
  output logic               all_gated_o
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_GATED = 2'd2;
  localparam logic [1:0] S_WAKE  = 2'd3;

  localparam int WCNT_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAKE_LAT - 1);

  logic [1:0]         r_state [N_TILES];
  logic [IDLE_W-1:0]  r_cnt   [N_TILES];
  logic [WCNT_W-1:0]  r_wcnt  [N_TILES];
  logic [N_TILES-1:0] r_clk_en;
  logic [N_TILES-1:0] r_ready;
  logic               r_all_gated;

  logic [1:0]         w_state_nxt [N_TILES];
  logic [IDLE_W-1:0]  w_cnt_nxt   [N_TILES];
  logic [WCNT_W-1:0]  w_wcnt_nxt  [N_TILES];
  logic [N_TILES-1:0] w_idle;
  logic [N_TILES-1:0] w_pend;
  logic [N_TILES-1:0] w_grant;
  logic [N_TILES-1:0] w_gated_nxt;

  // A wake request also blocks idling, so a same-cycle gate/wake never gates the tile.
  assign w_idle = ~busy_i & ~wake_req_i;

  always_comb begin
    for (int i = 0; i < N_TILES; i++) begin
      w_pend[i] = (r_state[i] == S_GATED) && (wake_req_i[i] || !cfg_enable_i);
    end
  end

`ifdef CGRA_CG_WAKE_STAGGER_EN
  localparam int PTR_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic             w_found;
  logic [PTR_W-1:0] w_idx;
  int               w_sum;

  always_comb begin
    w_grant   = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = '0;
    w_sum     = 0;
    for (int k = 0; k < N_TILES; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= N_TILES) w_sum = w_sum - N_TILES;
      w_idx = PTR_W'(w_sum);
      if (!w_found && w_pend[w_idx]) begin
        w_found        = 1'b1;
        w_grant[w_idx] = 1'b1;
        w_ptr_nxt      = (w_sum == N_TILES - 1) ? '0 : PTR_W'(w_sum + 1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`else
  assign w_grant = w_pend;
`endif

  always_comb begin
    for (int i = 0; i < N_TILES; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_wcnt_nxt[i]  = r_wcnt[i];
      case (r_state[i])
        S_RUN: begin
          if (cfg_enable_i && w_idle[i]) begin
            w_state_nxt[i] = S_COUNT;
            w_cnt_nxt[i]   = '0;
          end
        end
        S_COUNT: begin
          if (!w_idle[i] || !cfg_enable_i) begin
            w_state_nxt[i] = S_RUN;
            w_cnt_nxt[i]   = '0;
          end else if (r_cnt[i] >= cfg_idle_thr_i) begin
            w_state_nxt[i] = S_GATED;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + IDLE_W'(1);
          end
        end
        S_GATED: begin
          if (w_grant[i]) begin
            w_state_nxt[i] = S_WAKE;
            w_wcnt_nxt[i]  = WCNT_INIT;
          end
        end
        S_WAKE: begin
          if (r_wcnt[i] == '0) begin
            w_state_nxt[i] = S_RUN;
          end else begin
            w_wcnt_nxt[i] = r_wcnt[i] - WCNT_W'(1);
          end
        end
        default: w_state_nxt[i] = S_RUN;
      endcase
      w_gated_nxt[i] = (w_state_nxt[i] == S_GATED);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_TILES; i++) begin
        r_state[i] <= S_RUN;
        r_cnt[i]   <= '0;
        r_wcnt[i]  <= '0;
      end
      r_clk_en    <= '1;
      r_ready     <= '1;
      r_all_gated <= 1'b0;
    end else begin
      for (int i = 0; i < N_TILES; i++) begin
        r_state[i]  <= w_state_nxt[i];
        r_cnt[i]    <= w_cnt_nxt[i];
        r_wcnt[i]   <= w_wcnt_nxt[i];
        r_clk_en[i] <= (w_state_nxt[i] != S_GATED);
        r_ready[i]  <= (w_state_nxt[i] == S_RUN) || (w_state_nxt[i] == S_COUNT);
      end
      r_all_gated <= &w_gated_nxt;
    end
  end

  // Test override is combinational so scan sees running clocks without an edge.
  assign clk_en_o     = r_clk_en | {N_TILES{test_en_i}};
  assign tile_ready_o = r_ready;
  assign all_gated_o  = r_all_gated;

endmodule

// File: tb/tb_cgra_clock_gate_ctrl.sv
// Bench for cgra_clock_gate_ctrl: directed scenarios plus randomized traffic against a tile-activity model.
// Follows CGRA_CG_WAKE_STAGGER_EN when defined for the build.
module tb_cgra_clock_gate_ctrl;
  localparam int N  = 16;
  localparam int IW = 8;
  localparam int WL = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cfg_enable_i;
  logic [IW-1:0] cfg_idle_thr_i;
  logic          test_en_i;
  logic [N-1:0]  busy_i;
  logic [N-1:0]  wake_req_i;
  logic [N-1:0]  clk_en_o;
  logic [N-1:0]  tile_ready_o;
  logic          all_gated_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: per tile, gated flag, remaining wake cycles, and length of the current idle streak.
  bit m_gated  [N];
  int m_wleft  [N];
  int m_streak [N];
  int m_ptr;

  cgra_clock_gate_ctrl #(.N_TILES(N), .IDLE_W(IW), .WAKE_LAT(WL)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cfg_enable_i   (cfg_enable_i),
    .cfg_idle_thr_i (cfg_idle_thr_i),
    .test_en_i      (test_en_i),
    .busy_i         (busy_i),
    .wake_req_i     (wake_req_i),
    .clk_en_o       (clk_en_o),
    .tile_ready_o   (tile_ready_o),
    .all_gated_o    (all_gated_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_dut;
    rst_i          = 1'b1;
    busy_i         = '1;
    wake_req_i     = '0;
    cfg_enable_i   = 1'b1;
    cfg_idle_thr_i = 8'd4;
    test_en_i      = 1'b0;
    #2;
    rst_i = 1'b0;
  endtask

  task automatic model_reset;
    for (int i = 0; i < N; i++) begin
      m_gated[i]  = 1'b0;
      m_wleft[i]  = 0;
      m_streak[i] = 0;
    end
    m_ptr = 0;
  endtask

  // Advances the model by one edge using the inputs currently applied.
  task automatic model_step;
    bit pend [N];
    bit gnt  [N];
    int found;
    for (int i = 0; i < N; i++) pend[i] = m_gated[i] && (wake_req_i[i] || !cfg_enable_i);
`ifdef CGRA_CG_WAKE_STAGGER_EN
    found = -1;
    for (int k = 0; k < N; k++) begin
      if (found < 0 && pend[(m_ptr + k) % N]) found = (m_ptr + k) % N;
    end
    for (int i = 0; i < N; i++) gnt[i] = (i == found);
    if (found >= 0) m_ptr = (found + 1) % N;
`else
    found = 0;
    for (int i = 0; i < N; i++) gnt[i] = pend[i];
`endif
    for (int i = 0; i < N; i++) begin
      if (m_wleft[i] > 0) begin
        m_wleft[i]--;
      end else if (m_gated[i]) begin
        if (gnt[i]) begin
          m_gated[i] = 1'b0;
          m_wleft[i] = WL;
        end
      end else if (!busy_i[i] && !wake_req_i[i] && cfg_enable_i) begin
        if (m_streak[i] >= 1 && m_streak[i] - 1 >= int'(cfg_idle_thr_i)) begin
          m_gated[i]  = 1'b1;
          m_streak[i] = 0;
        end else begin
          m_streak[i]++;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    busy_i = '1; wake_req_i = '0; cfg_enable_i = 1'b1; cfg_idle_thr_i = 8'd4; test_en_i = 1'b0;
    #1;
    n_tests++; if (clk_en_o !== '1) begin n_fail++; $display("FAIL reset_clk_en got %h want ffff", clk_en_o); end
    n_tests++; if (tile_ready_o !== '1) begin n_fail++; $display("FAIL reset_ready got %h want ffff", tile_ready_o); end
    n_tests++; if (all_gated_o !== 1'b0) begin n_fail++; $display("FAIL reset_all_gated got %b want 0", all_gated_o); end
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_idle_gate;
    reset_dut();
    busy_i = ~(16'h1 << 3);
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) begin
        n_tests++; if (clk_en_o[3] !== 1'b1) begin n_fail++; $display("FAIL gate_early edge4 got %b want 1", clk_en_o[3]); end
      end
    end
    n_tests++; if (clk_en_o !== 16'hFFF7) begin n_fail++; $display("FAIL gate_clk_en edge5 got %h want fff7", clk_en_o); end
    n_tests++; if (tile_ready_o !== 16'hFFF7) begin n_fail++; $display("FAIL gate_ready edge5 got %h want fff7", tile_ready_o); end
  endtask

  task automatic test_abort;
    reset_dut();
    busy_i = ~(16'h1 << 3);
    repeat (3) tick();
    busy_i = '1;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_tests++; if (clk_en_o[3] !== 1'b1) begin n_fail++; $display("FAIL abort_hold cyc%0d got %b want 1", k, clk_en_o[3]); end
    end
    // A fresh idle period must take the full T+1 edges again.
    busy_i = ~(16'h1 << 3);
    repeat (5) tick();
    n_tests++; if (clk_en_o[3] !== 1'b1) begin n_fail++; $display("FAIL abort_restart edge4 got %b want 1", clk_en_o[3]); end
    tick();
    n_tests++; if (clk_en_o[3] !== 1'b0) begin n_fail++; $display("FAIL abort_restart edge5 got %b want 0", clk_en_o[3]); end
  endtask

  task automatic test_thr_lower;
    reset_dut();
    cfg_idle_thr_i = 8'd10;
    busy_i = ~(16'h1 << 3);
    repeat (6) tick();
    n_tests++; if (clk_en_o[3] !== 1'b1) begin n_fail++; $display("FAIL thr_cnt5 got %b want 1", clk_en_o[3]); end
    cfg_idle_thr_i = 8'd2;
    tick();
    n_tests++; if (clk_en_o[3] !== 1'b0) begin n_fail++; $display("FAIL thr_lowered got %b want 0", clk_en_o[3]); end
  endtask

  task automatic test_wake;
    reset_dut();
    busy_i = ~(16'h1 << 5);
    repeat (6) tick();
    n_tests++; if (clk_en_o[5] !== 1'b0) begin n_fail++; $display("FAIL wake_pre_gated got %b want 0", clk_en_o[5]); end
    busy_i = '1;
    tick();
    n_tests++; if (clk_en_o[5] !== 1'b0) begin n_fail++; $display("FAIL wake_busy_ignored got %b want 0", clk_en_o[5]); end
    wake_req_i = 16'h1 << 5;
    tick();
    wake_req_i = '0;
    n_tests++; if (clk_en_o[5] !== 1'b1) begin n_fail++; $display("FAIL wake_en_w got %b want 1", clk_en_o[5]); end
    n_tests++; if (tile_ready_o[5] !== 1'b0) begin n_fail++; $display("FAIL wake_rdy_w got %b want 0", tile_ready_o[5]); end
    tick();
    n_tests++; if (tile_ready_o[5] !== 1'b0) begin n_fail++; $display("FAIL wake_rdy_w1 got %b want 0", tile_ready_o[5]); end
    tick();
    n_tests++; if (tile_ready_o[5] !== 1'b1) begin n_fail++; $display("FAIL wake_rdy_w2 got %b want 1", tile_ready_o[5]); end
  endtask

  task automatic test_all_gated;
    reset_dut();
    cfg_idle_thr_i = 8'd0;
    busy_i = '0;
    repeat (2) tick();
    n_tests++; if (all_gated_o !== 1'b1) begin n_fail++; $display("FAIL allg_set got %b want 1", all_gated_o); end
    n_tests++; if (clk_en_o !== '0) begin n_fail++; $display("FAIL allg_clk_en got %h want 0000", clk_en_o); end
    cfg_enable_i = 1'b0;
    tick();
`ifdef CGRA_CG_WAKE_STAGGER_EN
    n_tests++; if (clk_en_o !== 16'h0001) begin n_fail++; $display("FAIL allg_first_grant got %h want 0001", clk_en_o); end
`else
    n_tests++; if (clk_en_o !== 16'hFFFF) begin n_fail++; $display("FAIL allg_first_grant got %h want ffff", clk_en_o); end
`endif
    n_tests++; if (all_gated_o !== 1'b0) begin n_fail++; $display("FAIL allg_drop got %b want 0", all_gated_o); end
    repeat (N + WL + 2) tick();
    n_tests++; if (clk_en_o !== '1) begin n_fail++; $display("FAIL allg_woken_en got %h want ffff", clk_en_o); end
    n_tests++; if (tile_ready_o !== '1) begin n_fail++; $display("FAIL allg_woken_rdy got %h want ffff", tile_ready_o); end
  endtask

  task automatic test_stagger;
    logic [N-1:0] exp_en [3];
`ifdef CGRA_CG_WAKE_STAGGER_EN
    exp_en[0] = 16'hFFF9; exp_en[1] = 16'hFFFB; exp_en[2] = 16'hFFFF;
`else
    exp_en[0] = 16'hFFFF; exp_en[1] = 16'hFFFF; exp_en[2] = 16'hFFFF;
`endif
    reset_dut();
    cfg_idle_thr_i = 8'd0;
    busy_i = 16'hFFF8;
    repeat (2) tick();
    n_tests++; if (clk_en_o !== 16'hFFF8) begin n_fail++; $display("FAIL stag_pre got %h want fff8", clk_en_o); end
    wake_req_i = 16'h0007;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++; if (clk_en_o !== exp_en[k]) begin n_fail++; $display("FAIL stag_edge%0d got %h want %h", k, clk_en_o, exp_en[k]); end
    end
    wake_req_i = '0;
  endtask

  task automatic test_test_en;
    reset_dut();
    cfg_idle_thr_i = 8'd0;
    busy_i = 16'hFFF8;
    repeat (2) tick();
    test_en_i = 1'b1;
    #1;
    n_tests++; if (clk_en_o !== '1) begin n_fail++; $display("FAIL testen_en got %h want ffff", clk_en_o); end
    n_tests++; if (tile_ready_o !== 16'hFFF8) begin n_fail++; $display("FAIL testen_rdy got %h want fff8", tile_ready_o); end
    n_tests++; if (all_gated_o !== 1'b0) begin n_fail++; $display("FAIL testen_allg got %b want 0", all_gated_o); end
    test_en_i = 1'b0;
    #1;
    n_tests++; if (clk_en_o !== 16'hFFF8) begin n_fail++; $display("FAIL testen_off got %h want fff8", clk_en_o); end
  endtask

  task automatic test_reset_mid_wake;
    reset_dut();
    cfg_idle_thr_i = 8'd0;
    busy_i = ~(16'h1 << 5);
    repeat (2) tick();
    busy_i = '1;
    wake_req_i = 16'h1 << 5;
    tick();
    wake_req_i = '0;
    n_tests++; if (tile_ready_o[5] !== 1'b0) begin n_fail++; $display("FAIL midwake_in_wake got %b want 0", tile_ready_o[5]); end
    #2;
    rst_i = 1'b1;
    #1;
    n_tests++; if (clk_en_o !== '1) begin n_fail++; $display("FAIL midwake_rst_en got %h want ffff", clk_en_o); end
    n_tests++; if (tile_ready_o !== '1) begin n_fail++; $display("FAIL midwake_rst_rdy got %h want ffff", tile_ready_o); end
    n_tests++; if (all_gated_o !== 1'b0) begin n_fail++; $display("FAIL midwake_rst_allg got %b want 0", all_gated_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_random;
    logic [N-1:0] e_en;
    logic [N-1:0] e_rdy;
    logic         e_all;
    reset_dut();
    cfg_idle_thr_i = 8'd2;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 99) == 0) cfg_enable_i = ~cfg_enable_i;
      if ($urandom_range(0, 49) == 0) cfg_idle_thr_i = IW'($urandom_range(0, 6));
      test_en_i = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) busy_i[i] = ~busy_i[i];
        wake_req_i[i] = ($urandom_range(0, 39) == 0);
      end
      model_step();
      tick();
      e_all = 1'b1;
      for (int i = 0; i < N; i++) begin
        e_en[i]  = !m_gated[i] || test_en_i;
        e_rdy[i] = !m_gated[i] && (m_wleft[i] == 0);
        e_all    = e_all && m_gated[i];
      end
      n_tests++; if (clk_en_o !== e_en) begin n_fail++; $display("FAIL rand_en cyc%0d got %h want %h", cyc, clk_en_o, e_en); end
      n_tests++; if (tile_ready_o !== e_rdy) begin n_fail++; $display("FAIL rand_rdy cyc%0d got %h want %h", cyc, tile_ready_o, e_rdy); end
      n_tests++; if (all_gated_o !== e_all) begin n_fail++; $display("FAIL rand_allg cyc%0d got %b want %b", cyc, all_gated_o, e_all); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_gate();
    test_abort();
    test_thr_lower();
    test_wake();
    test_all_gated();
    test_stagger();
    test_test_en();
    test_reset_mid_wake();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cgra_clock_gate_ctrl.md
Name: cgra_clock_gate_ctrl

Overview:
Per-tile clock-gating controller for the CGRA array. Watches each tile's busy flag, gates its clock after a programmable idle period, and re-enables it on wake request. It drives the en_i pins of the per-tile cluster_clock_gating cells. Optional staggered wake-up arbitrates re-enables to limit supply di/dt.

Parameters:
N_TILES, 16, number of gated tiles/clock-gate cells
IDLE_W, 8, width of idle counter and threshold
WAKE_LAT, 2, cycles from clock re-enable to tile_ready_o (must be >= 1)

Ports:
clk_i  in  1  ungated controller clock
rst_i  in  1  reset, asynchronous, active-high
cfg_enable_i  in  1  global gating enable; 0 = keep or bring all tiles running
cfg_idle_thr_i  in  IDLE_W  idle threshold T
test_en_i  in  1  scan/test mode; forces all clk_en_o high
busy_i  in  N_TILES  tile has work / is active
wake_req_i  in  N_TILES  request to ungate tile
clk_en_o  out  N_TILES  to en_i of each tile clock-gate cell
tile_ready_o  out  N_TILES  tile clock running and stable
all_gated_o  out  1  every tile in GATED

Behaviour:
- Reset (async, any time incl. mid-wake): all tiles RUN, clk_en_o = all 1, tile_ready_o = all 1, all_gated_o = 0, idle/wake counters 0, RR pointer 0.
- Per-tile FSM RUN / COUNT / GATED / WAKE; all outputs registered, updated on the same edge as the state.
- idle(i) = !busy_i[i] && !wake_req_i[i].
- RUN: cfg_enable_i && idle -> COUNT, cnt = 0. Else stay.
- COUNT: !idle or !cfg_enable_i -> RUN (cnt cleared). Else if cnt >= T -> GATED; else cnt++. The >= compare makes a lowered T mid-count take effect next cycle. T = 0 gates on the first COUNT cycle.
- Timing: busy sampled low at edge 0 -> clk_en_o[i] low after edge T+1.
- GATED: clk_en_o = 0, tile_ready_o = 0. busy_i is ignored. Wake pending when wake_req_i[i] || !cfg_enable_i. Granted pending tile -> WAKE, clk_en_o = 1, wcnt = WAKE_LAT-1.
- WAKE: clk_en_o = 1, tile_ready_o = 0. wcnt == 0 -> RUN with tile_ready_o = 1; else wcnt--. Not interruptible by cfg_enable_i or busy_i.
- Wake timing: granted at edge w -> clk_en_o high after edge w, tile_ready_o high after edge w+WAKE_LAT.
- all_gated_o = AND over tiles of next-state == GATED.
- test_en_i: clk_en_o = registered value OR test_en_i (combinational override). FSM, tile_ready_o and all_gated_o are unaffected.
- Gating request and wake request in the same cycle on the same tile: the wake wins, and the tile is never gated.

Optional Feature:
CGRA_CG_WAKE_STAGGER_EN
- Defined: at most one GATED->WAKE grant per cycle. Round-robin over pending tiles starts the search at the RR pointer; after a grant the pointer becomes granted+1 (mod N_TILES). Ungranted tiles stay GATED with clk_en_o = 0.
- Undefined: every pending tile is granted in the same cycle. No pointer logic.

Test Plan:
- T=4, cfg_enable_i=1, busy_i[3] 1->0 sampled at edge 0 and held -> clk_en_o[3] falls after edge 5, tile_ready_o[3] falls the same edge. All other tiles with busy=1 stay enabled.
- T=4, busy_i[3] low for 3 cycles then high -> clk_en_o[3] never drops, and the FSM returns to RUN. Lowering T from 10 to 2 while cnt=5 -> gated on the next edge.
- WAKE_LAT=2, tile 5 GATED, wake_req_i[5] pulse at edge w -> clk_en_o[5]=1 after edge w, tile_ready_o[5]=1 after edge w+2.
- All tiles gated (all_gated_o=1), then cfg_enable_i->0 -> all tiles wake and return to RUN; all_gated_o drops on the first grant.
- Stagger defined, pointer 0, tiles 0,1,2 gated with simultaneous wake_req -> clk_en_o rises for 0,1,2 on consecutive edges w, w+1, w+2. Undefined -> all three rise after edge w.
- test_en_i=1 with tiles gated -> clk_en_o all 1 the same cycle, tile_ready_o still 0. Assert rst_i mid-WAKE -> all outputs return to reset values immediately.
